// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported unified memory between instruction fetch and the MEM stage.
// Data requests win by default; a waiting fetch is served after two back-to-back data grants.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        INST = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t              state_r;
    logic [1:0]          data_streak_r;
    logic                mem_req_r;
    logic                mem_we_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic [DATA_W-1:0]   if_rdata_r;
    logic [DATA_W-1:0]   dm_rdata_r;
    logic                if_ack_r;
    logic                dm_ack_r;
    logic                busy_r;
    logic                grant_data_s;
    logic                grant_inst_s;
    logic [1:0]          streak_next_s;

    // Grant selection and next value of the consecutive-data counter
    always_comb begin
        grant_data_s  = 1'b0;
        grant_inst_s  = 1'b0;
        streak_next_s = 2'd0;
        if (dm_req && !((data_streak_r == 2'd2) && if_req)) begin
            grant_data_s = 1'b1;
        end else if (if_req) begin
            grant_inst_s = 1'b1;
        end else begin
            grant_data_s = 1'b0;
        end
        // The counter only tracks data grants taken while a fetch was kept waiting
        if (if_req && (data_streak_r != 2'd2)) begin
            streak_next_s = data_streak_r + 2'd1;
        end else if (if_req) begin
            streak_next_s = 2'd2;
        end else begin
            streak_next_s = 2'd0;
        end
    end

    // Arbitration FSM with all memory-side and requester-side outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            data_streak_r <= 2'd0;
            mem_req_r     <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= {ADDR_W{1'b0}};
            mem_wdata_r   <= {DATA_W{1'b0}};
            if_rdata_r    <= {DATA_W{1'b0}};
            dm_rdata_r    <= {DATA_W{1'b0}};
            if_ack_r      <= 1'b0;
            dm_ack_r      <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if_ack_r <= 1'b0;
                    dm_ack_r <= 1'b0;
                    if (grant_data_s) begin
                        state_r       <= DATA;
                        busy_r        <= 1'b1;
                        mem_req_r     <= 1'b1;
                        mem_we_r      <= dm_we;
                        mem_addr_r    <= dm_addr;
                        mem_wdata_r   <= dm_wdata;
                        data_streak_r <= streak_next_s;
                    end else if (grant_inst_s) begin
                        state_r       <= INST;
                        busy_r        <= 1'b1;
                        mem_req_r     <= 1'b1;
                        mem_we_r      <= 1'b0;
                        mem_addr_r    <= if_addr;
                        data_streak_r <= 2'd0;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                DATA: begin
                    if (mem_ack) begin
                        state_r   <= RESP;
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                        dm_ack_r  <= 1'b1;
                        if (!mem_we_r) begin
                            dm_rdata_r <= mem_rdata;
                        end
                    end
                end
                INST: begin
                    if (mem_ack) begin
                        state_r    <= RESP;
                        mem_req_r  <= 1'b0;
                        if_ack_r   <= 1'b1;
                        if_rdata_r <= mem_rdata;
                    end
                end
                RESP: begin
                    state_r  <= IDLE;
                    busy_r   <= 1'b0;
                    if_ack_r <= 1'b0;
                    dm_ack_r <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    busy_r    <= 1'b0;
                    mem_req_r <= 1'b0;
                    mem_we_r  <= 1'b0;
                    if_ack_r  <= 1'b0;
                    dm_ack_r  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign if_rdata  = if_rdata_r;
    assign dm_rdata  = dm_rdata_r;
    assign if_ack    = if_ack_r;
    assign dm_ack    = dm_ack_r;
    assign busy      = busy_r;
    assign stall_if  = if_req & ~if_ack_r;
    assign stall_mem = dm_req & ~dm_ack_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter with a transaction-level reference model and memory array.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ack;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          stall_if;
    logic          stall_mem;
    logic          busy;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: one memory transaction at a time, grants chosen by the priority rule
    typedef enum int {M_IDLE, M_ACC, M_RESP} mphase_t;
    mphase_t       m_phase;
    bit            m_inst;
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    int            m_streak;
    logic [DW-1:0] m_if_rdata;
    logic [DW-1:0] m_dm_rdata;
    bit            m_if_ack;
    bit            m_dm_ack;
    bit            m_new_grant;
    logic [DW-1:0] m_mem [16];
    int            ack_q [$];

    int lat_left, lat_min, lat_max, p_dm, p_if;
    bit scramble, auto_req, rand_rst, mem_manual;

    task automatic tick();
        logic          c_rst, c_dreq, c_dwe, c_ireq, c_mack;
        logic [AW-1:0] c_daddr, c_iaddr;
        logic [DW-1:0] c_dwd, c_mrd;
        c_rst = rst; c_dreq = dm_req; c_dwe = dm_we; c_ireq = if_req; c_mack = mem_ack;
        c_daddr = dm_addr; c_iaddr = if_addr; c_dwd = dm_wdata; c_mrd = mem_rdata;
        @(posedge clk);
        #1;
        m_new_grant = 1'b0;
        if (c_rst) begin
            m_phase = M_IDLE; m_streak = 0; m_if_rdata = '0; m_dm_rdata = '0;
            m_if_ack = 1'b0; m_dm_ack = 1'b0;
        end else begin
            case (m_phase)
                M_IDLE: begin
                    m_if_ack = 1'b0; m_dm_ack = 1'b0;
                    if (c_dreq && !(m_streak == 2 && c_ireq)) begin
                        m_inst = 1'b0; m_we = c_dwe; m_addr = c_daddr; m_wdata = c_dwd;
                        m_streak = c_ireq ? ((m_streak < 2) ? m_streak + 1 : 2) : 0;
                        m_phase = M_ACC; m_new_grant = 1'b1;
                    end else if (c_ireq) begin
                        m_inst = 1'b1; m_we = 1'b0; m_addr = c_iaddr; m_streak = 0;
                        m_phase = M_ACC; m_new_grant = 1'b1;
                    end
                end
                M_ACC: begin
                    if (c_mack) begin
                        m_phase = M_RESP;
                        if (m_inst) begin
                            m_if_rdata = c_mrd; m_if_ack = 1'b1;
                        end else begin
                            m_dm_ack = 1'b1;
                            if (m_we) m_mem[m_addr[5:2]] = m_wdata;
                            else m_dm_rdata = c_mrd;
                        end
                    end
                end
                default: begin
                    m_phase = M_IDLE; m_if_ack = 1'b0; m_dm_ack = 1'b0;
                end
            endcase
        end
        if (dm_ack === 1'b1) ack_q.push_back(0);
        if (if_ack === 1'b1) ack_q.push_back(1);
        check_val("busy", busy, m_phase != M_IDLE);
        check_val("mem_req", mem_req, m_phase == M_ACC);
        check_val("if_ack", if_ack, m_if_ack);
        check_val("dm_ack", dm_ack, m_dm_ack);
        check_val("if_rdata", if_rdata, m_if_rdata);
        check_val("dm_rdata", dm_rdata, m_dm_rdata);
        if (m_phase == M_ACC) begin
            check_val("mem_addr", mem_addr, m_addr);
            check_val("mem_we", mem_we, m_we);
            if (m_we) check_val("mem_wdata", mem_wdata, m_wdata);
        end
        if (c_rst) begin
            check_val("rst_mem_we", mem_we, 1'b0);
            check_val("rst_mem_addr", mem_addr, 0);
            check_val("rst_mem_wdata", mem_wdata, 0);
        end
    endtask

    // Requesters and memory respond to what the model says happened at the last edge
    task automatic drive();
        if (rand_rst) rst = ($urandom_range(149) == 0);
        if (m_dm_ack || !dm_req) dm_req = auto_req ? ($urandom_range(99) < p_dm) : 1'b0;
        if (m_if_ack || !if_req) if_req = auto_req ? ($urandom_range(99) < p_if) : 1'b0;
        if (scramble) begin
            dm_we    = $urandom_range(1);
            dm_addr  = 32'h80 + 32'($urandom_range(15)) * 32'd4;
            dm_wdata = $urandom;
            if_addr  = 32'($urandom_range(15)) * 32'd4;
        end
        if (!mem_manual) begin
            if (m_phase == M_ACC) begin
                if (m_new_grant) lat_left = $urandom_range(lat_max, lat_min);
                if (lat_left == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = (m_inst || !m_we) ? m_mem[m_addr[5:2]] : $urandom;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                    lat_left--;
                end
            end else begin
                mem_ack   = ($urandom_range(3) == 0);
                mem_rdata = $urandom;
            end
        end
        #1;
        check_val("stall_if", stall_if, if_req && !m_if_ack);
        check_val("stall_mem", stall_mem, dm_req && !m_dm_ack);
    endtask

    task automatic cycle();
        tick();
        drive();
    endtask

    task automatic run_until_idle(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            cycle();
            done = !dm_req && !if_req && (m_phase == M_IDLE);
        end
        check_val("idle_reached", done, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        m_phase = M_IDLE; m_streak = 0; m_if_rdata = '0; m_dm_rdata = '0;
        m_if_ack = 1'b0; m_dm_ack = 1'b0; m_new_grant = 1'b0;
        m_inst = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        for (int i = 0; i < 16; i++) m_mem[i] = $urandom;
        lat_left = 0; lat_min = 0; lat_max = 0; p_dm = 0; p_if = 0;
        scramble = 1'b0; auto_req = 1'b0; rand_rst = 1'b0; mem_manual = 1'b0;

        cycle();
        cycle();
        rst = 1'b0;

        // Load from 0x100 with one cycle of memory latency
        m_mem[0] = 32'hDEADBEEF;
        lat_min = 1; lat_max = 1;
        dm_we = 1'b0; dm_addr = 32'h100; dm_req = 1'b1;
        run_until_idle(20);
        check_val("load_rdata", dm_rdata, 32'hDEADBEEF);
        check_val("load_stall_mem", stall_mem, 1'b0);

        // Store to 0x20 with three cycles of latency; load data must not move
        ack_q.delete();
        lat_min = 3; lat_max = 3;
        dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'h12345678; dm_req = 1'b1;
        run_until_idle(20);
        check_val("store_ack_count", ack_q.size(), 1);
        check_val("store_rdata_kept", dm_rdata, 32'hDEADBEEF);

        // Simultaneous single requests: data first, then fetch
        ack_q.delete();
        lat_min = 1; lat_max = 1;
        dm_we = 1'b0; dm_addr = 32'h40; if_addr = 32'h0;
        dm_req = 1'b1; if_req = 1'b1;
        run_until_idle(30);
        check_val("simul_ack_count", ack_q.size(), 2);
        if (ack_q.size() >= 2) begin
            check_val("simul_first_data", ack_q[0], 0);
            check_val("simul_second_inst", ack_q[1], 1);
        end

        // Continuous contention with zero-latency memory
        ack_q.delete();
        lat_min = 0; lat_max = 0; p_dm = 100; p_if = 100; auto_req = 1'b1;
        dm_req = 1'b1; if_req = 1'b1;
        for (int i = 0; i < 60 && ack_q.size() < 9; i++) cycle();
        check_val("contention_acks", ack_q.size(), 9);
        for (int i = 0; i < ack_q.size() && i < 9; i++)
            check_val($sformatf("grant_order_%0d", i), ack_q[i], (i % 3 == 2) ? 1 : 0);
        auto_req = 1'b0;
        run_until_idle(30);

        // Reset in the middle of a fetch, stale mem_ack afterwards
        ack_q.delete();
        lat_min = 20; lat_max = 20;
        if_addr = 32'h8; if_req = 1'b1;
        cycle();
        cycle();
        cycle();
        mem_manual = 1'b1; mem_ack = 1'b0; rst = 1'b1; if_req = 1'b0;
        cycle();
        rst = 1'b0;
        cycle();
        cycle();
        mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        cycle();
        mem_ack = 1'b0;
        cycle();
        cycle();
        check_val("rst_no_ack", ack_q.size(), 0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_if_rdata", if_rdata, 0);
        mem_manual = 1'b0;

        // Randomized traffic with random latency, scrambled payloads and occasional reset
        lat_min = 0; lat_max = 3; p_dm = 40; p_if = 40;
        scramble = 1'b1; auto_req = 1'b1; rand_rst = 1'b1;
        for (int i = 0; i < 1500; i++) cycle();
        rand_rst = 1'b0; rst = 1'b0; auto_req = 1'b0; scramble = 1'b0;
        run_until_idle(60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all address ports.
REQ-002 Parameter DATA_W, default 32, data width of all data ports.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; ports `clk` and `rst`.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 if_req  in  1  instruction fetch request; level, held until if_ack.
REQ-007 if_addr  in  ADDR_W  fetch address.
REQ-008 if_rdata  out  DATA_W  fetched word; valid when if_ack=1.
REQ-009 if_ack  out  1  one-cycle fetch completion pulse.
REQ-010 dm_req  in  1  MEM-stage request (MemRead or MemWrite); level, held until dm_ack.
REQ-011 dm_we  in  1  1=store, 0=load.
REQ-012 dm_addr  in  ADDR_W  data address.
REQ-013 dm_wdata  in  DATA_W  store data.
REQ-014 dm_rdata  out  DATA_W  load data; valid when dm_ack=1 and access was a load.
REQ-015 dm_ack  out  1  one-cycle data completion pulse.
REQ-016 mem_req  out  1  request to the single-ported unified memory.
REQ-017 mem_we  out  1  memory write enable.
REQ-018 mem_addr  out  ADDR_W  memory address.
REQ-019 mem_wdata  out  DATA_W  memory write data.
REQ-020 mem_rdata  in  DATA_W  memory read data; valid with mem_ack.
REQ-021 mem_ack  in  1  memory completion pulse, any latency >=0 cycles after mem_req rises.
REQ-022 stall_if  out  1  = if_req & ~if_ack (combinational).
REQ-023 stall_mem  out  1  = dm_req & ~dm_ack (combinational).
REQ-024 busy  out  1  1 when state != IDLE.

Function
REQ-025 FSM states SHALL be IDLE, DATA, INST, RESP.
REQ-026 IDLE: if a data grant is selected -> DATA; else if if_req -> INST; else stay.
REQ-027 Grant priority: dm_req wins, except after 2 consecutive DATA grants while if_req was pending, the next grant SHALL go to INST if if_req=1.
REQ-028 Consecutive-data counter (2 bits) SHALL increment per DATA grant with if_req=1, clear on any INST grant or when if_req=0 at a DATA grant, saturate at 2.
REQ-029 On grant, addr/we/wdata SHALL be latched; requester input changes during the access are ignored; INST grants drive mem_we=0.
REQ-030 DATA/INST: mem_req=1 with latched mem_addr/mem_we/mem_wdata stable until mem_ack sampled high; then -> RESP.
REQ-031 On mem_ack, mem_rdata SHALL be registered into dm_rdata (DATA load) or if_rdata (INST); stores leave dm_rdata unchanged.
REQ-032 RESP: assert dm_ack or if_ack (matching the served requester) for exactly one cycle, mem_req=0, no new grant; -> IDLE.
REQ-033 Latency: request sampled in IDLE at cycle 0, mem_ack in cycle 1 -> ack in cycle 2; next grant earliest cycle 3.
REQ-034 mem_ack sampled in IDLE or RESP SHALL be ignored.
REQ-035 Simultaneous dm_req and if_req in IDLE with counter<2: DATA granted; if_req remains stalled.
REQ-036 if_rdata/dm_rdata SHALL hold their last value between acks.

Reset
REQ-037 rst=1 SHALL force, at the next edge: state IDLE, counter 0, mem_req 0, mem_we 0, if_ack 0, dm_ack 0, busy 0, if_rdata/dm_rdata/mem_addr/mem_wdata 0.
REQ-038 Reset during DATA/INST SHALL abandon the access with no ack generated; a later stale mem_ack is ignored per REQ-034.

Verification
REQ-039 Load: dm_req=1, dm_we=0, dm_addr=0x100, mem_ack 1 cycle after mem_req with mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_we=0, dm_ack pulse, dm_rdata=0xDEADBEEF, stall_mem low after ack.
REQ-040 Store: dm_we=1, dm_addr=0x20, dm_wdata=0x12345678, mem_ack after 3 cycles -> mem_we=1, data stable 3 cycles, one dm_ack, dm_rdata unchanged.
REQ-041 Contention: dm_req and if_req held high continuously, mem_ack 0-cycle latency -> grant order DATA, DATA, INST, repeating; no double acks.
REQ-042 Simultaneous single requests, if_addr=0x0, dm_addr=0x40 -> DATA first, INST second; stall_if high until its if_ack.
REQ-043 rst asserted mid-INST access, mem_ack arriving 2 cycles after reset -> all outputs at reset values, no if_ack, FSM stays IDLE.
